// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Widest sweep index: N_IN max 6, plus one guard bit.
    localparam int unsigned IdxMaxW = 7;

    function automatic logic [IdxMaxW-1:0] gray_enc(input logic [IdxMaxW-1:0] i);
        return i ^ (i >> 1);
    endfunction

endpackage

// File: rtl/tt_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, ticks for one cycle at terminal count.
module tt_dwell_timer #(
    parameter int unsigned DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper: drives every input vector, captures and checks the DUT response.
// Define TT_SWEEP_GRAY_EN to walk the vectors in Gray-code order instead of binary.
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned DWELL = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [(1<<N_IN)*N_OUT-1:0]    expected_tt,
    output logic [N_IN-1:0]               stim,
    input  logic [N_OUT-1:0]              dut_resp,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [N_IN:0]                 mismatch_count,
    output logic [N_IN-1:0]               first_fail_idx,
    output logic [(1<<N_IN)*N_OUT-1:0]    captured_tt
);

    localparam int unsigned NumVec = 1 << N_IN;
    localparam logic [N_IN:0] LastIdx = (N_IN + 1)'(NumVec - 1);

    function automatic logic [N_IN-1:0] order(input logic [N_IN:0] i);
`ifdef TT_SWEEP_GRAY_EN
        order = N_IN'(gray_enc(IdxMaxW'(i)));
`else
        order = N_IN'(i);
`endif
    endfunction

    state_e              state_q, state_d;
    logic [N_IN:0]       idx_q, idx_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_IN:0]       mm_q, mm_d;
    logic [N_IN-1:0]     ffi_q, ffi_d;
    logic [N_OUT-1:0]    cap_q [NumVec];
    logic [N_OUT-1:0]    cap_d [NumVec];
    logic [N_OUT-1:0]    exp_q [NumVec];
    logic [N_OUT-1:0]    exp_d [NumVec];
    logic [N_OUT-1:0]    exp_in [NumVec];
    logic [N_IN-1:0]     cur;
    logic                accept;
    logic                tick;

    // Unpacked views keep every table access indexed by an exact-width vector number.
    for (genvar g = 0; g < NumVec; g++) begin : g_tt
        assign exp_in[g]                      = expected_tt[g*N_OUT +: N_OUT];
        assign captured_tt[g*N_OUT +: N_OUT]  = cap_q[g];
    end

    assign accept = start && (state_q != StRun);

    tt_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == StRun),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stim_d  = stim_q;
        done_d  = done_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        ffi_d   = ffi_q;
        cap_d   = cap_q;
        exp_d   = exp_q;
        cur     = order(idx_q);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    stim_d  = order('0);
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    mm_d    = '0;
                    ffi_d   = '0;
                    cap_d   = '{default: '0};
                    exp_d   = exp_in;
                end
            end
            StRun: begin
                if (tick) begin
                    cap_d[cur] = dut_resp;
                    if (dut_resp != exp_q[cur]) begin
                        mm_d = mm_q + (N_IN + 1)'(1);
                        if (mm_q == '0) begin
                            ffi_d = cur;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        stim_d  = '0;
                        pass_d  = (mm_d == '0);
                    end else begin
                        idx_d  = idx_q + (N_IN + 1)'(1);
                        stim_d = order(idx_d);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            stim_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
            ffi_q   <= '0;
            cap_q   <= '{default: '0};
            exp_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            ffi_q   <= ffi_d;
            cap_q   <= cap_d;
            exp_q   <= exp_d;
        end
    end

    assign busy           = (state_q == StRun);
    assign stim           = stim_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_count = mm_q;
    assign first_fail_idx = ffi_q;

endmodule
